regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp_if.sv | 47 ++++
 rtl/regfile_mp.sv | 130 +++++++++++++
 tb/tb_regfile_mp.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp_if
//  Description : Bus bundle for the multi-port register file: two read
//                ports with pending bits, one byte-enabled write port,
//                scoreboard set port and clear-sequence control/status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0]   read_address1_i;
  logic [ADDR_W-1:0]   read_address2_i;
  logic [DATA_W-1:0]   read_data1_o;
  logic [DATA_W-1:0]   read_data2_o;
  logic                read_pend1_o;
  logic                read_pend2_o;
  logic [ADDR_W-1:0]   write_address_i;
  logic [DATA_W-1:0]   write_data_i;
  logic [DATA_W/8-1:0] write_be_i;
  logic                ctrl_reg_write_i;
  logic                pend_set_i;
  logic [ADDR_W-1:0]   pend_address_i;
  logic                clear_req_i;
  logic                busy_o;
  logic                write_ready_o;

  // Requester side: drives addresses, write data and control.
  modport master (
    output read_address1_i, read_address2_i,
    input  read_data1_o, read_data2_o, read_pend1_o, read_pend2_o,
    output write_address_i, write_data_i, write_be_i, ctrl_reg_write_i,
    output pend_set_i, pend_address_i, clear_req_i,
    input  busy_o, write_ready_o
  );

  // Register file side.
  modport slave (
    input  read_address1_i, read_address2_i,
    output read_data1_o, read_data2_o, read_pend1_o, read_pend2_o,
    input  write_address_i, write_data_i, write_be_i, ctrl_reg_write_i,
    input  pend_set_i, pend_address_i, clear_req_i,
    output busy_o, write_ready_o
  );
endinterface
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp
//  Description : Dual-read, single-write register file with byte enables,
//                optional write-to-read forwarding, a per-register pending
//                (scoreboard) bit and a sequential full-file clear engine.
//                Register 0 is hard-wired to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  wire logic     clk_i,
  input  wire logic     rst_i,
  regfile_mp_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int BE_W  = DATA_W / 8;
  localparam logic [ADDR_W-1:0] c_idx_last = {ADDR_W{1'b1}};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_index;
  logic              r_busy;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_pend;

  logic              w_wr_accept;
  logic              w_pend_accept;
  logic [DATA_W-1:0] w_old;
  logic [DATA_W-1:0] w_merged;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;

  // Writes and scoreboard sets are refused while clearing; address 0 is inert.
  assign w_wr_accept   = bus.ctrl_reg_write_i && !r_busy &&
                         (bus.write_address_i != '0);
  assign w_pend_accept = bus.pend_set_i && !r_busy &&
                         (bus.pend_address_i != '0);

  assign w_old = r_mem[bus.write_address_i];

  // Byte-merge of incoming write data over the currently stored word.
  for (genvar b = 0; b < BE_W; b++) begin : g_byte
    assign w_merged[8*b +: 8] = bus.write_be_i[b] ? bus.write_data_i[8*b +: 8]
                                                  : w_old[8*b +: 8];
  end

  // Read data: zero for register 0, forwarded merge on a matching write, else stored.
  always_comb begin
    w_rd1 = r_mem[bus.read_address1_i];
    w_rd2 = r_mem[bus.read_address2_i];
    if ((BYPASS != 0) && w_wr_accept && (bus.read_address1_i == bus.write_address_i))
      w_rd1 = w_merged;
    if ((BYPASS != 0) && w_wr_accept && (bus.read_address2_i == bus.write_address_i))
      w_rd2 = w_merged;
    if (bus.read_address1_i == '0)
      w_rd1 = '0;
    if (bus.read_address2_i == '0)
      w_rd2 = '0;
  end

  assign bus.read_data1_o  = w_rd1;
  assign bus.read_data2_o  = w_rd2;
  // Pending bits always reflect stored state, never the in-flight update.
  assign bus.read_pend1_o  = (bus.read_address1_i == '0) ? 1'b0 : r_pend[bus.read_address1_i];
  assign bus.read_pend2_o  = (bus.read_address2_i == '0) ? 1'b0 : r_pend[bus.read_address2_i];
  assign bus.busy_o        = r_busy;
  assign bus.write_ready_o = !r_busy;

  // Clear sequencer: walks index 1..DEPTH-1, busy is a registered output.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_index <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.clear_req_i) begin
            r_state <= CLEAR;
            r_index <= {{(ADDR_W-1){1'b0}}, 1'b1};
            r_busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (r_index == c_idx_last) begin
            r_state <= IDLE;
            r_index <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_index <= r_index + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_index <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Storage update: clear engine has priority; otherwise write, then pend set (set wins).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
      r_pend <= '0;
    end else if (r_busy) begin
      r_mem[r_index]  <= '0;
      r_pend[r_index] <= 1'b0;
    end else begin
      if (w_wr_accept) begin
        r_mem[bus.write_address_i]  <= w_merged;
        r_pend[bus.write_address_i] <= 1'b0;
      end
      if (w_pend_accept)
        r_pend[bus.pend_address_i] <= 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_mp
//  Description : Self-checking bench for regfile_mp (forwarding and
//                non-forwarding instances driven with identical stimulus).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5)) bus_b ();
  regfile_mp_if #(.DATA_W(32), .ADDR_W(5)) bus_n ();

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_b.slave)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_dut_nb (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_n.slave)
  );

  typedef struct packed {
    logic        wr;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        ps;
    logic [4:0]  pa;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        ep1;
    logic        ep2;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [3:0] be, input logic ps, input logic [4:0] pa,
                        input logic clr, input logic [4:0] ra1, input logic [4:0] ra2);
    bus_b.ctrl_reg_write_i = wr;  bus_n.ctrl_reg_write_i = wr;
    bus_b.write_address_i  = wa;  bus_n.write_address_i  = wa;
    bus_b.write_data_i     = wd;  bus_n.write_data_i     = wd;
    bus_b.write_be_i       = be;  bus_n.write_be_i       = be;
    bus_b.pend_set_i       = ps;  bus_n.pend_set_i       = ps;
    bus_b.pend_address_i   = pa;  bus_n.pend_address_i   = pa;
    bus_b.clear_req_i      = clr; bus_n.clear_req_i      = clr;
    bus_b.read_address1_i  = ra1; bus_n.read_address1_i  = ra1;
    bus_b.read_address2_i  = ra2; bus_n.read_address2_i  = ra2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    //          wr wa    wd            be    ps pa    ra1   ra2   e1            e2            p1 p2
    vecs[0]  = '{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd0, 5'd0, 5'd3, 32'h0,        32'h0,        1'b0, 1'b0};
    vecs[1]  = '{1'b1, 5'd3, 32'hAAAAAAAA, 4'hF, 1'b0, 5'd0, 5'd3, 5'd0, 32'hAAAAAAAA, 32'h0,        1'b0, 1'b0};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd0, 5'd3, 5'd3, 32'hAAAAAAAA, 32'hAAAAAAAA, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 5'd4, 32'h55555555, 4'hF, 1'b0, 5'd0, 5'd4, 5'd3, 32'h55555555, 32'hAAAAAAAA, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 5'd4, 32'h12345678, 4'h5, 1'b0, 5'd0, 5'd4, 5'd4, 32'h55345578, 32'h55345578, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd0, 5'd4, 5'd3, 32'h55345578, 32'hAAAAAAAA, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0};
    vecs[7]  = '{1'b0, 5'd0, 32'h0,        4'h0, 1'b1, 5'd5, 5'd5, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0};
    vecs[8]  = '{1'b1, 5'd5, 32'h5,        4'hF, 1'b1, 5'd5, 5'd5, 5'd0, 32'h5,        32'h0,        1'b1, 1'b0};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd0, 5'd5, 5'd0, 32'h5,        32'h0,        1'b1, 1'b0};
    vecs[10] = '{1'b1, 5'd5, 32'h6,        4'hF, 1'b0, 5'd0, 5'd5, 5'd0, 32'h6,        32'h0,        1'b1, 1'b0};
    vecs[11] = '{1'b0, 5'd0, 32'h0,        4'h0, 1'b1, 5'd0, 5'd5, 5'd0, 32'h6,        32'h0,        1'b0, 1'b0};
    vecs[12] = '{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd0, 5'd0, 5'd5, 32'h0,        32'h6,        1'b0, 1'b0};

    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check("reset_busy", {31'b0, bus_b.busy_o}, 32'h0);
    check("reset_ready", {31'b0, bus_b.write_ready_o}, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Table-driven vectors: combinational view before each edge.
    for (int i = 0; i < 13; i++) begin
      set_in(vecs[i].wr, vecs[i].wa, vecs[i].wd, vecs[i].be, vecs[i].ps, vecs[i].pa,
             1'b0, vecs[i].ra1, vecs[i].ra2);
      #1;
      check($sformatf("vec%0d_rd1", i), bus_b.read_data1_o, vecs[i].e1);
      check($sformatf("vec%0d_rd2", i), bus_b.read_data2_o, vecs[i].e2);
      check($sformatf("vec%0d_pend1", i), {31'b0, bus_b.read_pend1_o}, {31'b0, vecs[i].ep1});
      check($sformatf("vec%0d_pend2", i), {31'b0, bus_b.read_pend2_o}, {31'b0, vecs[i].ep2});
      check($sformatf("vec%0d_ready", i), {31'b0, bus_b.write_ready_o}, 32'h1);
      tick();
    end

    // Non-forwarding instance: old value in the write cycle, new value after.
    set_in(1, 7, 32'h77777777, 4'hF, 0, 0, 0, 7, 0);
    #1;
    check("nobyp_same_cycle", bus_n.read_data1_o, 32'h0);
    check("byp_same_cycle", bus_b.read_data1_o, 32'h77777777);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 7, 0);
    #1;
    check("nobyp_next_cycle", bus_n.read_data1_o, 32'h77777777);
    tick();

    // Clear sequence: fill 1..31 (pending set too), last write coincides with clear_req.
    for (int a = 1; a < 31; a++) begin
      set_in(1, a[4:0], 32'h1000_0000 + a, 4'hF, 1, a[4:0], 0, 0, 0);
      tick();
    end
    set_in(1, 5'd31, 32'h1000_001F, 4'hF, 1, 5'd31, 1, 0, 0);
    tick();
    set_in(1, 5'd2, 32'hDEAD, 4'hF, 1, 5'd3, 1, 5'd1, 5'd31);
    cnt = 0;
    #1;
    while (bus_b.busy_o && cnt < 100) begin
      cnt++;
      if (cnt == 1)
        check("clear_ready_low", {31'b0, bus_b.write_ready_o}, 32'h0);
      if (cnt == 5) begin
        check("clear_mid_cleared", bus_b.read_data1_o, 32'h0);
        check("clear_mid_uncleared", bus_b.read_data2_o, 32'h1000_001F);
        check("clear_mid_pend", {31'b0, bus_b.read_pend2_o}, 32'h1);
      end
      tick();
      #1;
    end
    check("clear_busy_cycles", cnt, 32'd31);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("clear_done_ready", {31'b0, bus_b.write_ready_o}, 32'h1);
    for (int a = 0; a < 32; a++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, a[4:0], 5'(31 - a));
      #1;
      check($sformatf("post_clear_rd_%0d", a), bus_b.read_data1_o, 32'h0);
      check($sformatf("post_clear_pend_%0d", a), {31'b0, bus_b.read_pend1_o}, 32'h0);
    end
    tick();

    // Reset asserted mid-cycle ten cycles into a clear sequence.
    set_in(1, 5'd20, 32'h20202020, 4'hF, 0, 0, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 1, 5'd20, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 5'd20, 0);
    #1;
    check("rst_pre_busy", {31'b0, bus_b.busy_o}, 32'h1);
    check("rst_pre_data", bus_b.read_data1_o, 32'h20202020);
    repeat (9) tick();
    #3;
    rst = 1'b1;
    #1;
    check("rst_busy_now", {31'b0, bus_b.busy_o}, 32'h0);
    check("rst_ready_now", {31'b0, bus_b.write_ready_o}, 32'h1);
    check("rst_data_now", bus_b.read_data1_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    set_in(1, 5'd11, 32'hBEEF, 4'hF, 0, 0, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 5'd11, 5'd20);
    #1;
    check("post_rst_write", bus_b.read_data1_o, 32'hBEEF);
    check("post_rst_other", bus_b.read_data2_o, 32'h0);
    check("post_rst_busy", {31'b0, bus_b.busy_o}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
